// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, RV32I opcodes, funct7 values and
// the issued-operation record handed from the issue stage to the ALU.
package alu_pkg;

   // ALU control codes
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_ORR   = 4'd2;
   localparam logic [3:0] ALU_AND   = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_LSL   = 4'd5;
   localparam logic [3:0] ALU_LSR   = 4'd6;
   localparam logic [3:0] ALU_ASR   = 4'd7;
   localparam logic [3:0] ALU_SLT   = 4'd8;
   localparam logic [3:0] ALU_SLTU  = 4'd9;
   localparam logic [3:0] ALU_GEQ   = 4'd10;
   localparam logic [3:0] ALU_GEQU  = 4'd11;
   localparam logic [3:0] ALU_XORID = 4'd12;

   // RV32I major opcodes
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // funct7 values
   localparam logic [6:0] F7_ZERO = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   // One decoded operation as presented to the ALU
   typedef struct packed {
      logic [3:0]  control;
      logic [31:0] data_a;
      logic [31:0] data_b;
      logic [4:0]  rd;
      logic        we;
      logic        br;
      logic        br_inv;
      logic        illegal;
   } issue_t;

   // The ALU reads the shift amount from operand B bits [24:20]
   function automatic logic [31:0] shamt_operand(input logic [4:0] amt);
      return {7'b0, amt, 20'b0};
   endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I immediate extraction for all five immediate formats.
module rv32_imm_gen
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm_i,
   output logic [31:0] imm_s,
   output logic [31:0] imm_b,
   output logic [31:0] imm_u,
   output logic [31:0] imm_j
);

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/alu_issue_decoder.sv
// Decode/issue stage: decodes an RV32I instruction into ALU control and
// operands and holds the result in a single valid/ready pipeline slot.
module alu_issue_decoder
   import alu_pkg::*;
#(
   parameter int         WIDTH      = 32,
   parameter logic [6:0] CUSTOM_OPC = 7'b0001011
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [31:0]      INSTR,
   input  logic [WIDTH-1:0] PC,
   input  logic [WIDTH-1:0] RS1_DATA,
   input  logic [WIDTH-1:0] RS2_DATA,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [3:0]       CONTROL,
   output logic [WIDTH-1:0] DATA_A,
   output logic [WIDTH-1:0] DATA_B,
   output logic [4:0]       RD,
   output logic             WE,
   output logic             BR,
   output logic             BR_INV,
   output logic             ILLEGAL,
   output logic             ILL_STICKY
);

   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic        f7_zero, f7_alt;
   logic        capture;
   logic        slot_valid;
   logic        ill_sticky;
   issue_t      dec;
   issue_t      slot;

   rv32_imm_gen u_imm_gen (
      .instr (INSTR),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_b (imm_b),
      .imm_u (imm_u),
      .imm_j (imm_j)
   );

   // Branch/jump target immediates are not needed at this stage
   logic unused_imm;
   assign unused_imm = ^{imm_b, imm_j};

   assign opcode  = INSTR[6:0];
   assign funct3  = INSTR[14:12];
   assign funct7  = INSTR[31:25];
   assign f7_zero = (funct7 == F7_ZERO);
   assign f7_alt  = (funct7 == F7_ALT);

   // Decode the presented instruction into an ALU operation
   always_comb begin
      // NOTE: every field gets a default before the case so no path leaves dec unassigned (no latch).
      dec         = '0;
      dec.control = ALU_ADD;
      dec.rd      = INSTR[11:7];
      case (opcode)
         OPC_OP: begin
            dec.data_a = RS1_DATA;
            dec.data_b = RS2_DATA;
            dec.we     = 1'b1;
            case (funct3)
               3'b000: begin
                  dec.control = f7_alt ? ALU_SUB : ALU_ADD;
                  dec.illegal = !(f7_zero || f7_alt);
               end
               3'b001: begin
                  dec.control = ALU_LSL;
                  dec.data_b  = shamt_operand(RS2_DATA[4:0]);
                  dec.illegal = !f7_zero;
               end
               3'b010: begin dec.control = ALU_SLT;  dec.illegal = !f7_zero; end
               3'b011: begin dec.control = ALU_SLTU; dec.illegal = !f7_zero; end
               3'b100: begin dec.control = ALU_XOR;  dec.illegal = !f7_zero; end
               3'b101: begin
                  dec.control = f7_alt ? ALU_ASR : ALU_LSR;
                  dec.data_b  = shamt_operand(RS2_DATA[4:0]);
                  dec.illegal = !(f7_zero || f7_alt);
               end
               3'b110: begin dec.control = ALU_ORR; dec.illegal = !f7_zero; end
               default: begin dec.control = ALU_AND; dec.illegal = !f7_zero; end
            endcase
         end
         OPC_OP_IMM: begin
            dec.data_a = RS1_DATA;
            dec.data_b = imm_i;
            dec.we     = 1'b1;
            case (funct3)
               3'b000: dec.control = ALU_ADD;
               3'b001: begin
                  dec.control = ALU_LSL;
                  dec.data_b  = shamt_operand(INSTR[24:20]);
                  dec.illegal = !f7_zero;
               end
               3'b010: dec.control = ALU_SLT;
               3'b011: dec.control = ALU_SLTU;
               3'b100: dec.control = ALU_XOR;
               3'b101: begin
                  dec.control = f7_alt ? ALU_ASR : ALU_LSR;
                  dec.data_b  = shamt_operand(INSTR[24:20]);
                  dec.illegal = !(f7_zero || f7_alt);
               end
               3'b110: dec.control = ALU_ORR;
               default: dec.control = ALU_AND;
            endcase
         end
         OPC_LOAD, OPC_JALR: begin
            dec.data_a = RS1_DATA;
            dec.data_b = imm_i;
            dec.we     = 1'b1;
         end
         OPC_STORE: begin
            dec.data_a = RS1_DATA;
            dec.data_b = imm_s;
         end
         OPC_LUI: begin
            dec.data_b = imm_u;
            dec.we     = 1'b1;
         end
         OPC_AUIPC: begin
            dec.data_a = PC;
            dec.data_b = imm_u;
            dec.we     = 1'b1;
         end
         OPC_JAL: begin
            dec.data_a = PC;
            dec.data_b = 32'd4;
            dec.we     = 1'b1;
         end
         OPC_BRANCH: begin
            dec.data_a = RS1_DATA;
            dec.data_b = RS2_DATA;
            dec.br     = 1'b1;
            case (funct3)
               3'b000: dec.control = ALU_SUB;
               3'b001: begin dec.control = ALU_SUB; dec.br_inv = 1'b1; end
               3'b100: dec.control = ALU_SLT;
               3'b101: dec.control = ALU_GEQ;
               3'b110: dec.control = ALU_SLTU;
               3'b111: dec.control = ALU_GEQU;
               default: dec.illegal = 1'b1;
            endcase
         end
         CUSTOM_OPC: begin
            dec.control = ALU_XORID;
            dec.data_b  = RS1_DATA;
            dec.we      = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase

      // An illegal op is issued as a harmless add of zeros
      if (dec.illegal) begin
         dec.control = ALU_ADD;
         dec.data_a  = '0;
         dec.data_b  = '0;
         dec.br      = 1'b0;
         dec.br_inv  = 1'b0;
      end
      if (dec.illegal || (dec.rd == 5'd0)) dec.we = 1'b0;
   end

   // Slot is free when empty or when its op leaves this cycle
   assign IN_READY = !slot_valid || OUT_READY;
   assign capture  = IN_VALID && IN_READY && !FLUSH;

   // Pipeline slot: flush beats capture, capture beats drain; data holds after drain
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         slot_valid <= 1'b0;
         slot       <= '0;
         ill_sticky <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every slot field updates from pre-edge values together.
         if (FLUSH) begin
            slot_valid <= 1'b0;
         end else if (capture) begin
            slot_valid <= 1'b1;
            slot       <= dec;
            if (dec.illegal) ill_sticky <= 1'b1;
         end else if (OUT_READY) begin
            slot_valid <= 1'b0;
         end
      end
   end

   assign OUT_VALID  = slot_valid;
   assign CONTROL    = slot.control;
   assign DATA_A     = slot.data_a;
   assign DATA_B     = slot.data_b;
   assign RD         = slot.rd;
   assign WE         = slot.we;
   assign BR         = slot.br;
   assign BR_INV     = slot.br_inv;
   assign ILLEGAL    = slot.illegal;
   assign ILL_STICKY = ill_sticky;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Self-checking bench for alu_issue_decoder: table of instruction vectors
// with hand-derived expectations, scoreboard queue, and directed sequences
// for stall, flush and asynchronous reset.
module tb_alu_issue_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] instr = '0, pc = '0, rs1 = '0, rs2 = '0;
   logic        in_ready, out_valid, we, br, br_inv, illegal, ill_sticky;
   logic [3:0]  control;
   logic [31:0] data_a, data_b;
   logic [4:0]  rd;

   alu_issue_decoder dut (
      .CLK        (clk),
      .RST        (rst),
      .FLUSH      (flush),
      .IN_VALID   (in_valid),
      .IN_READY   (in_ready),
      .INSTR      (instr),
      .PC         (pc),
      .RS1_DATA   (rs1),
      .RS2_DATA   (rs2),
      .OUT_VALID  (out_valid),
      .OUT_READY  (out_ready),
      .CONTROL    (control),
      .DATA_A     (data_a),
      .DATA_B     (data_b),
      .RD         (rd),
      .WE         (we),
      .BR         (br),
      .BR_INV     (br_inv),
      .ILLEGAL    (illegal),
      .ILL_STICKY (ill_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr, pc, rs1, rs2;
      logic [3:0]  ctrl;
      logic [31:0] a, b;
      logic [4:0]  rd;
      logic        we, br, br_inv, ill, sticky;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];
   vec_t sb[$];
   vec_t cur;
   logic sticky_model = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] i, p, r1, r2, input logic [3:0] c,
                               input logic [31:0] a, b, input logic [4:0] d,
                               input logic w, bb, bi, il);
      vec_t v;
      v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
      v.ctrl = c; v.a = a; v.b = b; v.rd = d;
      v.we = w; v.br = bb; v.br_inv = bi; v.ill = il; v.sticky = 1'b0;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      cur   = v;
      instr = v.instr;
      pc    = v.pc;
      rs1   = v.rs1;
      rs2   = v.rs2;
   endtask

   task automatic compare_out(input string tag, input vec_t e);
      check({tag, "_control"}, control, e.ctrl);
      check({tag, "_data_a"},  data_a,  e.a);
      check({tag, "_data_b"},  data_b,  e.b);
      check({tag, "_rd"},      rd,      e.rd);
      check({tag, "_we"},      we,      e.we);
      check({tag, "_br"},      br,      e.br);
      check({tag, "_br_inv"},  br_inv,  e.br_inv);
      check({tag, "_illegal"}, illegal, e.ill);
      check({tag, "_sticky"},  ill_sticky, e.sticky);
   endtask

   // One clock: observe at the falling edge, then advance past the rising edge
   task automatic cycle(output logic accepted);
      logic exp_valid;
      vec_t e;
      @(negedge clk);
      exp_valid = (sb.size() != 0);
      check("out_valid", out_valid, exp_valid);
      check("in_ready", in_ready, !exp_valid || out_ready);
      if (out_valid && out_ready) begin
         if (sb.size() == 0) check("fire_without_op", 1, 0);
         else begin
            e = sb.pop_front();
            compare_out("issue", e);
         end
      end else if (flush && sb.size() != 0) begin
         void'(sb.pop_front());
      end
      accepted = in_valid && in_ready && !flush;
      if (accepted) begin
         e = cur;
         sticky_model = sticky_model | e.ill;
         e.sticky = sticky_model;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic acc;
      vec_t held;

      //            instr         pc        rs1           rs2       ctl a             b             rd we br bi il
      vecs.push_back(mk(32'h002081B3, 0,        5,            7,        0,  5,            7,            3, 1, 0, 0, 0)); // add
      vecs.push_back(mk(32'h40208233, 0,        10,           3,        1,  10,           3,            4, 1, 0, 0, 0)); // sub
      vecs.push_back(mk(32'h40335293, 0,        32'hF0000000, 0,        7,  32'hF0000000, 32'h00300000, 5, 1, 0, 0, 0)); // srai 3
      vecs.push_back(mk(32'h002093B3, 0,        32'h11,       32'h25,   5,  32'h11,       32'h00500000, 7, 1, 0, 0, 0)); // sll reg
      vecs.push_back(mk(32'h01F4D413, 0,        32'h80,       0,        6,  32'h80,       32'h01F00000, 8, 1, 0, 0, 0)); // srli 31
      vecs.push_back(mk(32'hFFF00093, 0,        32'h1234,     0,        0,  32'h1234,     32'hFFFFFFFF, 1, 1, 0, 0, 0)); // addi -1
      vecs.push_back(mk(32'h0020F2B3, 0,        32'hF0,       32'h3C,   3,  32'hF0,       32'h3C,       5, 1, 0, 0, 0)); // and
      vecs.push_back(mk(32'h00209063, 0,        9,            9,        1,  9,            9,            0, 0, 1, 1, 0)); // bne
      vecs.push_back(mk(32'h0020F463, 0,        3,            4,        11, 3,            4,            8, 0, 1, 0, 0)); // bgeu
      vecs.push_back(mk(32'h12345537, 0,        77,           0,        0,  0,            32'h12345000, 10, 1, 0, 0, 0)); // lui
      vecs.push_back(mk(32'h00001597, 32'h100,  0,            0,        0,  32'h100,      32'h1000,     11, 1, 0, 0, 0)); // auipc
      vecs.push_back(mk(32'h008000EF, 32'h200,  0,            0,        0,  32'h200,      4,            1, 1, 0, 0, 0)); // jal
      vecs.push_back(mk(32'h0020A223, 0,        32'h1000,     32'h55,   0,  32'h1000,     4,            4, 0, 0, 0, 0)); // sw
      vecs.push_back(mk(32'hFFC0A303, 0,        32'h2000,     0,        0,  32'h2000,     32'hFFFFFFFC, 6, 1, 0, 0, 0)); // lw -4
      vecs.push_back(mk(32'h0000848B, 0,        32'hDEADBEEF, 1,        12, 0,            32'hDEADBEEF, 9, 1, 0, 0, 0)); // xorid
      vecs.push_back(mk(32'h00208033, 0,        1,            2,        0,  1,            2,            0, 0, 0, 0, 0)); // add x0
      vecs.push_back(mk(32'h022081B3, 0,        5,            7,        0,  0,            0,            3, 0, 0, 0, 1)); // bad f7
      vecs.push_back(mk(32'h40309293, 0,        5,            0,        0,  0,            0,            5, 0, 0, 0, 1)); // slli f7=0x20
      vecs.push_back(mk(32'h0020A063, 0,        5,            7,        0,  0,            0,            0, 0, 0, 0, 1)); // branch f3=010
      vecs.push_back(mk(32'h0000007F, 0,        5,            7,        0,  0,            0,            0, 0, 0, 0, 1)); // opcode 0x7F
      vecs.push_back(mk(32'h002081B3, 0,        8,            9,        0,  8,            9,            3, 1, 0, 0, 0)); // legal after illegal

      // Reset state while RST is held
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_control", control, 0);
      check("rst_data_a", data_a, 0);
      check("rst_data_b", data_b, 0);
      check("rst_rd", rd, 0);
      check("rst_we", we, 0);
      check("rst_br", br, 0);
      check("rst_br_inv", br_inv, 0);
      check("rst_illegal", illegal, 0);
      check("rst_sticky", ill_sticky, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back stream at full throughput
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         drive(vecs[i]);
         in_valid = 1'b1;
         cycle(acc);
         check("stream_accept", acc, 1);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 10 && sb.size() != 0; k++) cycle(acc);
      check("stream_drained", sb.size(), 0);

      // Same stream under random backpressure
      foreach (vecs[i]) begin
         drive(vecs[i]);
         in_valid = 1'b1;
         acc = 1'b0;
         for (int k = 0; k < 20 && !acc; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            cycle(acc);
         end
         check("bp_accept", acc, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 10 && sb.size() != 0; k++) cycle(acc);
      check("bp_drained", sb.size(), 0);

      // Stall: hold op 0 for 3 cycles with op 1 waiting, then swap in one cycle
      out_ready = 1'b0;
      drive(vecs[0]);
      in_valid = 1'b1;
      cycle(acc);
      check("stall_first_accept", acc, 1);
      held = vecs[0];
      drive(vecs[1]);
      repeat (3) begin
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
         check("stall_control", control, held.ctrl);
         check("stall_data_a", data_a, held.a);
         check("stall_data_b", data_b, held.b);
         check("stall_rd", rd, held.rd);
         cycle(acc);
         check("stall_no_accept", acc, 0);
      end
      out_ready = 1'b1;
      cycle(acc);
      check("stall_swap_accept", acc, 1);
      in_valid = 1'b0;
      cycle(acc);
      check("stall_empty_after", out_valid, 0);

      // Flush kills the held op and the incoming one
      out_ready = 1'b0;
      drive(vecs[2]);
      in_valid = 1'b1;
      cycle(acc);
      check("flush_pre_valid", out_valid, 1);
      drive(vecs[3]);
      flush = 1'b1;
      cycle(acc);
      check("flush_no_accept", acc, 0);
      check("flush_out_valid", out_valid, 0);
      cycle(acc);
      check("flush_empty_in", out_valid, 0);
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      cycle(acc);

      // Asynchronous reset mid-cycle with an illegal op held
      out_ready = 1'b0;
      drive(vecs[19]);
      in_valid = 1'b1;
      cycle(acc);
      in_valid = 1'b0;
      check("arst_pre_valid", out_valid, 1);
      check("arst_pre_sticky", ill_sticky, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_illegal", illegal, 0);
      check("arst_sticky", ill_sticky, 0);
      check("arst_data_a", data_a, 0);
      check("arst_data_b", data_b, 0);
      check("arst_rd", rd, 0);
      check("arst_control", control, 0);
      sb.delete();
      sticky_model = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Legal op after reset leaves sticky clear
      out_ready = 1'b1;
      drive(vecs[1]);
      in_valid = 1'b1;
      cycle(acc);
      in_valid = 1'b0;
      cycle(acc);
      check("post_rst_sticky", ill_sticky, 0);
      check("post_rst_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue_decoder.md
Name: alu_issue_decoder

Overview:
Decode/issue stage that drives the RV32I ALU. Accepts a fetched instruction with its register operands and PC, and decodes it into the ALU's 4-bit control code and two 32-bit operands. Results are held in a registered, valid/ready-handshaked pipeline slot that sits between register-file read and the ALU input. Branch qualifiers, writeback controls and an illegal-instruction flag travel with the operation.

Parameters:
WIDTH, 32, datapath width; only 32 is supported.
CUSTOM_OPC, 7'b0001011, opcode decoded as XORID (custom-0).

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
FLUSH  input  1  synchronous; kills held and incoming op
IN_VALID  input  1  instruction/operands valid
IN_READY  output  1  stage can accept this cycle
INSTR  input  32  instruction word
PC  input  32  instruction address
RS1_DATA  input  32  register rs1 value
RS2_DATA  input  32  register rs2 value
OUT_VALID  output  1  issued op valid
OUT_READY  input  1  ALU side accepts
CONTROL  output  4  ALU control code
DATA_A  output  32  ALU operand A
DATA_B  output  32  ALU operand B
RD  output  5  destination register
WE  output  1  op writes RD
BR  output  1  op is conditional branch
BR_INV  output  1  branch taken when ALU flag is 0 (bne)
ILLEGAL  output  1  unsupported encoding
ILL_STICKY  output  1  set on any issued illegal op; cleared only by RST

Behaviour:
- Reset (async, RST=1): OUT_VALID=0, CONTROL=0, DATA_A=0, DATA_B=0, RD=0, WE=0, BR=0, BR_INV=0, ILLEGAL=0, ILL_STICKY=0.
- IN_READY = !OUT_VALID || OUT_READY. This is combinational and is the only comb path from output to input.
- Capture when IN_VALID && IN_READY: all outputs load on the next edge, OUT_VALID=1. Latency is 1 cycle. Back-to-back throughput is 1 op/cycle while OUT_READY=1.
- Output fire without a new capture: OUT_VALID goes to 0 next edge. Data outputs hold their last value.
- Outputs are stable while OUT_VALID && !OUT_READY.
- FLUSH=1: OUT_VALID goes to 0 next edge and no capture occurs, regardless of IN_VALID. FLUSH has priority over capture.
- Control codes: ADD 0, SUB 1, ORR 2, AND 3, XOR 4, LSL 5, LSR 6, ASR 7, SLT 8, SLTU 9, GEQ 10, GEQU 11, XORID 12.
- Shift amount placement: the ALU takes shamt from DATA_B[24:20]. For all shifts, DATA_B = {7'b0, amt[4:0], 20'b0}; amt = RS2_DATA[4:0] (register) or INSTR[24:20] (immediate).
- OP 0110011, A=rs1, B=rs2, WE=1:
  - f3=000: f7 0x00 -> ADD, f7 0x20 -> SUB.
  - f3=001 -> LSL; 010 -> SLT; 011 -> SLTU; 100 -> XOR.
  - f3=101: f7 0x00 -> LSR, f7 0x20 -> ASR.
  - f3=110 -> ORR; 111 -> AND.
  - Any other f7 is ILLEGAL.
- OP-IMM 0010011: A=rs1, B=sign-extended I-imm, WE=1, same f3 map without SUB. slli/srli require f7=0x00; srai requires f7=0x20; otherwise ILLEGAL.
- LOAD 0000011 and JALR 1100111: ADD, A=rs1, B=I-imm, WE=1.
- STORE 0100011: ADD, A=rs1, B=S-imm, WE=0.
- LUI 0110111: ADD, A=0, B=U-imm, WE=1.
- AUIPC 0010111: ADD, A=PC, B=U-imm, WE=1.
- JAL 1101111: ADD, A=PC, B=4, WE=1 (link value).
- BRANCH 1100011: A=rs1, B=rs2, BR=1, WE=0.
  - beq -> SUB; bne -> SUB with BR_INV=1.
  - blt -> SLT; bge -> GEQ; bltu -> SLTU; bgeu -> GEQU.
  - f3 010/011 -> ILLEGAL.
- CUSTOM_OPC: XORID, A=0, B=rs1, WE=1.
- Any other opcode: ILLEGAL=1, CONTROL=ADD, A=B=0, WE=0, BR=0.
- For all ops RD=INSTR[11:7]. WE is forced to 0 when RD=0 or ILLEGAL=1.
- ILL_STICKY sets on the edge that captures an illegal op, including when FLUSH is not asserted that cycle.

Decomposition:
- Shared package alu_pkg: 4-bit ALU control localparams, RV32I opcode constants, funct7 constants 0x00 and 0x20. The ALU and this block both use it.
- One sub-module, rv32_imm_gen: purely combinational I/S/B/U/J immediate extraction, reused later by branch target logic.
- Handshake register and decode mux stay in the top.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, OUT_READY=1 -> next cycle OUT_VALID=1, CONTROL=0, A=5, B=7, RD=3, WE=1.
- srai x5,x6,3 (0x40335293), rs1=0xF0000000 -> CONTROL=7, B=0x00300000, WE=1, ILLEGAL=0.
- bne x1,x2 (f3=001), rs1=rs2=9 -> CONTROL=1, BR=1, BR_INV=1, WE=0.
- OUT_READY=0 for 3 cycles with IN_VALID held:
  - IN_READY=0 after the first capture.
  - Outputs stable.
  - On OUT_READY=1 the next op captures the same cycle the held op fires.
- Opcode 0x7F -> ILLEGAL=1, CONTROL=0, A=B=0, WE=0, ILL_STICKY=1; ILL_STICKY stays 1 after later legal ops.
- FLUSH with IN_VALID=1 -> OUT_VALID=0 next edge, no capture. RST asserted mid-stream clears all outputs immediately, without waiting for CLK.
